// File: rtl/biquad_cascade_if.sv
// Sample, result and coefficient-write signals of biquad_cascade.
// The master side drives samples and coefficients; the slave side is the filter.
interface biquad_cascade_if #(
  parameter int data_width = 16,
  parameter int SEC_W      = 2
);
  logic signed [data_width-1:0] sample_in;
  logic                         start;
  logic                         ready;
  logic signed [data_width-1:0] sample_out;
  logic                         out_valid;
  logic signed [data_width-1:0] param_in;
  logic [SEC_W-1:0]             param_section;
  logic [2:0]                   param_target;
  logic                         write_param;
  logic                         clear_state;

  modport master (
    output sample_in, start, param_in, param_section, param_target, write_param, clear_state,
    input  ready, sample_out, out_valid
  );

  modport slave (
    input  sample_in, start, param_in, param_section, param_target, write_param, clear_state,
    output ready, sample_out, out_valid
  );
endinterface

// File: rtl/biquad_cascade.sv
// Time-multiplexed cascade of Direct-Form-I biquads sharing one multiply-accumulate unit.
// Define BIQUAD_CASCADE_SATURATE_EN to clamp each section result instead of wrapping it.
module biquad_cascade #(
  parameter int data_width = 16,
  parameter int N_SECTIONS = 4,
  parameter int SEC_W      = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  biquad_cascade_if.slave  bus
);
  localparam int PROD_W = 2 * data_width;
  localparam int ACC_W  = 2 * data_width + 4;
  localparam int FRAC   = data_width - 2;
  localparam logic signed [data_width-1:0] B0_ONE = {2'b01, {(data_width-2){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t                       state_r;
  state_t                       next_s;
  logic [SEC_W-1:0]             section_r;
  logic [2:0]                   mac_r;
  logic signed [data_width-1:0] cur_x_r;
  logic signed [ACC_W-1:0]      acc_r;
  logic signed [data_width-1:0] coef_r [N_SECTIONS][5];
  logic signed [data_width-1:0] x1_r [N_SECTIONS];
  logic signed [data_width-1:0] x2_r [N_SECTIONS];
  logic signed [data_width-1:0] y1_r [N_SECTIONS];
  logic signed [data_width-1:0] y2_r [N_SECTIONS];
  logic signed [data_width-1:0] sample_out_r;
  logic                         out_valid_r;

  logic                         accept_s;
  logic                         last_sec_s;
  logic                         coef_wr_s;
  logic signed [data_width-1:0] coef_s;
  logic signed [data_width-1:0] data_s;
  logic signed [PROD_W-1:0]     prod_s;
  logic signed [ACC_W-1:0]      prod_ext_s;
  logic signed [ACC_W-1:0]      acc_next_s;
  logic signed [data_width-1:0] y_s;

  assign accept_s   = (state_r == IDLE) && bus.start && !bus.clear_state;
  assign last_sec_s = (section_r == SEC_W'(N_SECTIONS - 1));
  assign coef_wr_s  = bus.write_param && (bus.param_target < 3'd5) &&
                      ({1'b0, bus.param_section} < (SEC_W+1)'(N_SECTIONS));

`ifdef BIQUAD_CASCADE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

  function automatic logic signed [data_width-1:0] sat_reduce(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    sh = v >>> FRAC;
    if (sh > SAT_MAX) begin
      return SAT_MAX[data_width-1:0];
    end else if (sh < SAT_MIN) begin
      return SAT_MIN[data_width-1:0];
    end else begin
      return sh[data_width-1:0];
    end
  endfunction

  assign y_s = sat_reduce(acc_r);
`else
  // Shift-then-truncate is just a bit slice of the accumulator.
  assign y_s = acc_r[FRAC +: data_width];
`endif

  // Operand pair for the current MAC step; feedback terms are subtracted.
  always_comb begin
    coef_s = '0;
    data_s = '0;
    case (mac_r)
      3'd0: begin coef_s = coef_r[section_r][0]; data_s = cur_x_r;          end
      3'd1: begin coef_s = coef_r[section_r][1]; data_s = x1_r[section_r];  end
      3'd2: begin coef_s = coef_r[section_r][2]; data_s = x2_r[section_r];  end
      3'd3: begin coef_s = coef_r[section_r][3]; data_s = y1_r[section_r];  end
      3'd4: begin coef_s = coef_r[section_r][4]; data_s = y2_r[section_r];  end
      default: begin coef_s = '0; data_s = '0; end
    endcase
    prod_s     = coef_s * data_s;
    prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    if (mac_r >= 3'd3) begin
      acc_next_s = acc_r - prod_ext_s;
    end else begin
      acc_next_s = acc_r + prod_ext_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; clear_state aborts any sample in flight.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_s = MAC;
        else          next_s = IDLE;
      end
      MAC: begin
        if (bus.clear_state)    next_s = IDLE;
        else if (mac_r == 3'd4) next_s = WB;
        else                    next_s = MAC;
      end
      WB: begin
        if (bus.clear_state)  next_s = IDLE;
        else if (last_sec_s)  next_s = IDLE;
        else                  next_s = MAC;
      end
      default: next_s = IDLE;
    endcase
  end

  // Datapath, histories and output. The final writeback registers the result
  // directly so out_valid coincides with IDLE and a new start can overlap it.
  always_ff @(posedge clk) begin
    if (reset) begin
      section_r    <= '0;
      mac_r        <= 3'd0;
      cur_x_r      <= '0;
      acc_r        <= '0;
      sample_out_r <= '0;
      out_valid_r  <= 1'b0;
      for (int k = 0; k < N_SECTIONS; k++) begin
        x1_r[k] <= '0;
        x2_r[k] <= '0;
        y1_r[k] <= '0;
        y2_r[k] <= '0;
      end
    end else begin
      out_valid_r <= 1'b0;
      if (bus.clear_state) begin
        for (int k = 0; k < N_SECTIONS; k++) begin
          x1_r[k] <= '0;
          x2_r[k] <= '0;
          y1_r[k] <= '0;
          y2_r[k] <= '0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.start) begin
              cur_x_r   <= bus.sample_in;
              section_r <= '0;
              mac_r     <= 3'd0;
              acc_r     <= '0;
            end
          end
          MAC: begin
            acc_r <= acc_next_s;
            mac_r <= mac_r + 3'd1;
          end
          WB: begin
            x2_r[section_r] <= x1_r[section_r];
            x1_r[section_r] <= cur_x_r;
            y2_r[section_r] <= y1_r[section_r];
            y1_r[section_r] <= y_s;
            cur_x_r         <= y_s;
            acc_r           <= '0;
            mac_r           <= 3'd0;
            if (last_sec_s) begin
              sample_out_r <= y_s;
              out_valid_r  <= 1'b1;
            end else begin
              section_r <= section_r + SEC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Coefficient bank; out-of-range section or target writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_SECTIONS; k++) begin
        coef_r[k][0] <= B0_ONE;
        for (int t = 1; t < 5; t++) begin
          coef_r[k][t] <= '0;
        end
      end
    end else if (coef_wr_s) begin
      coef_r[bus.param_section][bus.param_target] <= bus.param_in;
    end
  end

  assign bus.ready      = (state_r == IDLE);
  assign bus.sample_out = sample_out_r;
  assign bus.out_valid  = out_valid_r;
endmodule

// File: tb/tb_biquad_cascade.sv
// Directed-vector bench for biquad_cascade (N_SECTIONS=4, data_width=16).
// Expected values are hand-computed filter outputs.
module tb_biquad_cascade;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  biquad_cascade_if #(.data_width(16), .SEC_W(2)) bif ();

  biquad_cascade #(.data_width(16), .N_SECTIONS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] sec, input logic [2:0] tgt, input logic signed [15:0] val);
    @(negedge clk);
    bif.param_section = sec;
    bif.param_target  = tgt;
    bif.param_in      = val;
    bif.write_param   = 1'b1;
    @(negedge clk);
    bif.write_param   = 1'b0;
  endtask

  // Returns at the negedge of the out_valid cycle; lat = edges after acceptance, -1 on timeout.
  task automatic do_sample(input logic signed [15:0] s, output logic signed [15:0] y, output int lat);
    @(negedge clk);
    bif.sample_in = s;
    bif.start     = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    lat = -1;
    y   = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bif.out_valid) begin
        lat = k;
        y   = bif.sample_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bif.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0b expected 1", bif.ready); end
    vectors++;
    if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b expected 0", bif.out_valid); end
    vectors++;
    if (bif.sample_out !== 16'sd0) begin miscompares++; $display("FAIL reset_sample_out: got %0d expected 0", bif.sample_out); end
  endtask

  task automatic test_identity();
    logic signed [15:0] y;
    int lat;
    do_sample(16'sd1234, y, lat);
    vectors++;
    if (y !== 16'sd1234) begin miscompares++; $display("FAIL identity_pos: got %0d expected 1234", y); end
    vectors++;
    if (lat !== 24) begin miscompares++; $display("FAIL identity_latency: got %0d expected 24", lat); end
    @(negedge clk);
    vectors++;
    if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL out_valid_width: got %0b expected 0", bif.out_valid); end
    do_sample(-16'sd1234, y, lat);
    vectors++;
    if (y !== -16'sd1234) begin miscompares++; $display("FAIL identity_neg: got %0d expected -1234", y); end
  endtask

  task automatic test_scale();
    logic signed [15:0] y;
    int lat;
    do_reset();
    write_coef(2'd0, 3'd0, 16'sd8192);
    do_sample(16'sd1000, y, lat);
    vectors++;
    if (y !== 16'sd500) begin miscompares++; $display("FAIL scale_half: got %0d expected 500", y); end
    do_sample(-16'sd1001, y, lat);
    vectors++;
    if (y !== -16'sd501) begin miscompares++; $display("FAIL scale_floor: got %0d expected -501", y); end
  endtask

  task automatic test_recursion();
    logic signed [15:0] y;
    logic signed [15:0] exp_y [4];
    int lat;
    exp_y[0] = 16'sd16384; exp_y[1] = 16'sd8192; exp_y[2] = 16'sd4096; exp_y[3] = 16'sd2048;
    do_reset();
    write_coef(2'd0, 3'd3, -16'sd8192);
    for (int n = 0; n < 4; n++) begin
      do_sample((n == 0) ? 16'sd16384 : 16'sd0, y, lat);
      vectors++;
      if (y !== exp_y[n]) begin miscompares++; $display("FAIL recursion_%0d: got %0d expected %0d", n, y, exp_y[n]); end
    end
  endtask

  task automatic test_saturate();
    logic signed [15:0] y;
    logic signed [15:0] exp_y;
    int lat;
`ifdef BIQUAD_CASCADE_SATURATE_EN
    exp_y = 16'sh8000;
`else
    exp_y = 16'sd5536;
`endif
    do_reset();
    write_coef(2'd0, 3'd0, 16'sh8000);
    do_sample(16'sd30000, y, lat);
    vectors++;
    if (y !== exp_y) begin miscompares++; $display("FAIL overflow_reduce: got %0d expected %0d", y, exp_y); end
  endtask

  task automatic test_abort();
    logic signed [15:0] y;
    int lat;
    int pulses;
    do_reset();
    write_coef(2'd0, 3'd3, -16'sd8192);
    do_sample(16'sd16384, y, lat);
    @(negedge clk);
    bif.sample_in = 16'sd16384;
    bif.start     = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    @(negedge clk);
    bif.clear_state = 1'b1;
    @(negedge clk);
    bif.clear_state = 1'b0;
    vectors++;
    if (bif.ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %0b expected 1", bif.ready); end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bif.out_valid) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL abort_no_valid: got %0d pulses expected 0", pulses); end
    do_sample(16'sd16384, y, lat);
    vectors++;
    if (y !== 16'sd16384) begin miscompares++; $display("FAIL abort_fresh_0: got %0d expected 16384", y); end
    do_sample(16'sd0, y, lat);
    vectors++;
    if (y !== 16'sd8192) begin miscompares++; $display("FAIL abort_fresh_1: got %0d expected 8192", y); end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] y;
    int lat;
    do_reset();
    write_coef(2'd0, 3'd0, 16'sd8192);
    do_sample(16'sd100, y, lat);
    vectors++;
    if (y !== 16'sd50) begin miscompares++; $display("FAIL b2b_first: got %0d expected 50", y); end
    bif.sample_in = 16'sd200;
    bif.start     = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bif.out_valid) begin
        lat = k;
        y   = bif.sample_out;
        break;
      end
    end
    vectors++;
    if (lat !== 24) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 24", lat); end
    vectors++;
    if (y !== 16'sd100) begin miscompares++; $display("FAIL b2b_second: got %0d expected 100", y); end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] y;
    int lat;
    int pulses;
    do_reset();
    write_coef(2'd0, 3'd0, 16'sd8192);
    do_sample(16'sd1000, y, lat);
    vectors++;
    if (y !== 16'sd500) begin miscompares++; $display("FAIL midreset_pre: got %0d expected 500", y); end
    @(negedge clk);
    bif.sample_in = 16'sd2000;
    bif.start     = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bif.ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready: got %0b expected 1", bif.ready); end
    vectors++;
    if (bif.sample_out !== 16'sd0) begin miscompares++; $display("FAIL midreset_sample_out: got %0d expected 0", bif.sample_out); end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bif.out_valid) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", pulses); end
    write_coef(2'd0, 3'd5, 16'sd0);
    write_coef(2'd0, 3'd7, 16'sd0);
    do_sample(16'sd1234, y, lat);
    vectors++;
    if (y !== 16'sd1234) begin miscompares++; $display("FAIL midreset_identity: got %0d expected 1234", y); end
  endtask

  initial begin
    bif.sample_in     = '0;
    bif.start         = 1'b0;
    bif.param_in      = '0;
    bif.param_section = '0;
    bif.param_target  = 3'd0;
    bif.write_param   = 1'b0;
    bif.clear_state   = 1'b0;
    test_reset();
    test_identity();
    test_scale();
    test_recursion();
    test_saturate();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
